// File: rtl/fetch_pipe_ctrl.sv
// Fetch-stage pipeline control: PC register, IF/ID and ID/EX registers,
// saturating stall/flush statistics and a sticky stall watchdog.
module fetch_pipe_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned WATCHDOG = 16,
   parameter int unsigned CTRL_W   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write,
   input  logic              ifid_write,
   input  logic              ifid_flush,
   input  logic              hazard,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic [31:0]       instr_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   output logic [31:0]       pc,
   output logic [31:0]       ifid_instr,
   output logic [31:0]       ifid_pc4,
   output logic              ifid_valid,
   output logic [CTRL_W-1:0] idex_ctrl,
   output logic [1:0]        fetch_state,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt,
   output logic              stall_timeout
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2,
      HUNG  = 2'd3
   } fetch_state_e;

   localparam logic [7:0] WD_LIMIT = 8'(WATCHDOG);

   logic [31:0]       pc_q, pc_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic [31:0]       ifid_pc4_q, ifid_pc4_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
   fetch_state_e      state_q, state_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic [15:0]       flush_cnt_q, flush_cnt_d;
   logic [7:0]        run_q, run_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      idex_ctrl_d  = hazard ? '0 : ctrl_in;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      run_d        = '0;
      timeout_d    = timeout_q;
      state_d      = RUN;

      if (pc_write) begin
         pc_d = branch_taken ? branch_target : pc_plus4;
      end

      if (ifid_flush) begin
         ifid_instr_d = '0;
         ifid_pc4_d   = '0;
         ifid_valid_d = 1'b0;
      end else if (ifid_write) begin
         ifid_instr_d = instr_in;
         ifid_pc4_d   = pc_plus4;
         ifid_valid_d = 1'b1;
      end

      if (!pc_write && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
      if (ifid_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 16'd1;

      // Run length saturates at the limit so the trip condition stays true
      if (!pc_write) run_d = (run_q >= WD_LIMIT) ? WD_LIMIT : run_q + 8'd1;
      if (run_d == WD_LIMIT && !pc_write) timeout_d = 1'b1;

      // Watchdog takes priority on the same edge it trips; once set it never clears
      if (timeout_d)      state_d = HUNG;
      else if (ifid_flush) state_d = FLUSH;
      else if (!pc_write)  state_d = STALL;
      else                 state_d = RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
         idex_ctrl_q  <= '0;
         state_q      <= RUN;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         run_q        <= '0;
         timeout_q    <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         idex_ctrl_q  <= idex_ctrl_d;
         state_q      <= state_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         run_q        <= run_d;
         timeout_q    <= timeout_d;
      end
   end

   assign pc            = pc_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc4      = ifid_pc4_q;
   assign ifid_valid    = ifid_valid_q;
   assign idex_ctrl     = idex_ctrl_q;
   assign fetch_state   = state_q;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;
   assign stall_timeout = timeout_q;

endmodule
